// File: rtl/mem_request_unit.sv
// In-order load/store request queue that drives the Cache data port and returns tagged load results.
// Optional MEM_REQ_EXT_EN: sign/zero-extend byte and half load results locally instead of in the Cache.
module mem_request_unit #(
  parameter int DEPTH_LOG = 2,
  parameter int TAG_W     = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_write,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              rob_clear,
  output logic              mem_need_data,
  output logic              mem_is_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_work_type,
  input  logic              mem_handle,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [31:0]       res_data
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  typedef logic [DEPTH_LOG-1:0] ptr_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t state, state_next;

  logic             q_write  [DEPTH];
  logic             q_commit [DEPTH];
  logic [2:0]       q_type   [DEPTH];
  logic [31:0]      q_addr   [DEPTH];
  logic [31:0]      q_wdata  [DEPTH];
  logic [TAG_W-1:0] q_tag    [DEPTH];

  ptr_t head, tail;
  cnt_t count;

  logic [DEPTH-1:0] live;
  cnt_t             n_commit;
  logic             run;
  ptr_t             idx, off;
  logic             head_ok;
  logic             issue, drop_req, pop, push, res_fire;

`ifdef MEM_REQ_EXT_EN
  function automatic logic [31:0] shape(input logic [2:0] t, input logic [31:0] d);
    case (t[1:0])
      2'b00:   return t[2] ? {{24{d[7]}}, d[7:0]}   : {24'h0, d[7:0]};
      2'b01:   return t[2] ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction
`endif

  // Occupancy mask plus the length of the committed-store run starting at head,
  // which is what survives a rob_clear.
  always_comb begin
    live     = '0;
    n_commit = '0;
    run      = 1'b1;
    idx      = '0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = ptr_t'(i) - head;
      live[ptr_t'(i)] = cnt_t'(off) < count;
      idx = head + ptr_t'(i);
      if (run && (cnt_t'(i) < count) && q_write[idx] && q_commit[idx])
        n_commit = n_commit + cnt_t'(1);
      else
        run = 1'b0;
    end
  end

  assign head_ok = (count != '0) && (!q_write[head] || q_commit[head]);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    drop_req   = 1'b0;
    pop        = 1'b0;
    res_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (head_ok && !rob_clear) begin
          issue      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_handle) begin
          drop_req = 1'b1;
          if (mem_is_write) begin
            pop        = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = rob_clear ? DRAIN : WAIT;
          end
        end else if (rob_clear && !mem_is_write) begin
          drop_req   = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT: begin
        // A mem_ready coinciding with the flush is the flushed load's own reply.
        if (rob_clear) begin
          state_next = mem_ready ? IDLE : DRAIN;
        end else if (mem_ready) begin
          res_fire   = 1'b1;
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rdy_in) begin
      state_next = state;
      issue      = 1'b0;
      drop_req   = 1'b0;
      pop        = 1'b0;
      res_fire   = 1'b0;
    end
  end

  assign req_ready = rst_in && rdy_in && !rob_clear && ((count != cnt_t'(DEPTH)) || pop);
  assign push      = req_valid && req_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else if (rdy_in) state <= state_next;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_write[ptr_t'(i)]  <= 1'b0;
        q_commit[ptr_t'(i)] <= 1'b0;
        q_type[ptr_t'(i)]   <= '0;
        q_addr[ptr_t'(i)]   <= '0;
        q_wdata[ptr_t'(i)]  <= '0;
        q_tag[ptr_t'(i)]    <= '0;
      end
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (commit_valid && live[ptr_t'(i)] && q_write[ptr_t'(i)] && (q_tag[ptr_t'(i)] == commit_tag))
          q_commit[ptr_t'(i)] <= 1'b1;
      end
      if (push) begin
        q_write[tail]  <= req_is_write;
        q_commit[tail] <= 1'b0;
        q_type[tail]   <= req_type;
        q_addr[tail]   <= req_addr;
        q_wdata[tail]  <= req_wdata;
        q_tag[tail]    <= req_tag;
      end
      if (rob_clear) begin
        tail  <= head + ptr_t'(n_commit);
        head  <= head + ptr_t'(pop);
        count <= n_commit - cnt_t'(pop);
      end else begin
        tail  <= tail + ptr_t'(push);
        head  <= head + ptr_t'(pop);
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_need_data <= 1'b0;
      mem_is_write  <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_work_type <= '0;
      res_valid     <= 1'b0;
      res_tag       <= '0;
      res_data      <= '0;
    end else if (rdy_in) begin
      res_valid <= res_fire;
      if (res_fire) begin
        res_tag  <= q_tag[head];
`ifdef MEM_REQ_EXT_EN
        res_data <= shape(mem_work_type, mem_rdata);
`else
        res_data <= mem_rdata;
`endif
      end
      if (issue) begin
        mem_need_data <= 1'b1;
        mem_is_write  <= q_write[head];
        mem_addr      <= q_addr[head];
        mem_wdata     <= q_wdata[head];
        mem_work_type <= q_type[head];
      end else if (drop_req) begin
        mem_need_data <= 1'b0;
      end
    end else begin
      // A frozen cycle must not stretch a result pulse.
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed, self-checking bench for mem_request_unit: table-driven basic load/store flow plus
// hand-written sequences for queue wrap, flushes, extension, freeze and async reset.
module tb_mem_request_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        req_valid, req_ready, req_is_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_tag;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic        rob_clear;
  logic        mem_need_data, mem_is_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_work_type;
  logic        mem_handle, mem_ready;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic [3:0]  res_tag;
  logic [31:0] res_data;

  int total = 0;
  int bad   = 0;

  mem_request_unit #(.DEPTH_LOG(2), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .rob_clear(rob_clear),
    .mem_need_data(mem_need_data), .mem_is_write(mem_is_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_work_type(mem_work_type), .mem_handle(mem_handle),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .res_valid(res_valid),
    .res_tag(res_tag), .res_data(res_data)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        v, wr;
    logic [2:0]  typ;
    logic [31:0] addr, wdata;
    logic [3:0]  tag;
    logic        cv;
    logic [3:0]  ctag;
    logic        h, r;
    logic [31:0] rdata;
    logic        e_rdy, e_need, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic        e_res;
    logic [3:0]  e_tag;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic wr, logic [2:0] typ, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] tag, logic cv, logic [3:0] ctag, logic h, logic r,
                              logic [31:0] rdata, logic e_rdy, logic e_need, logic e_wr,
                              logic [31:0] e_addr, logic [31:0] e_wdata, logic e_res,
                              logic [3:0] e_tag, logic [31:0] e_data);
    vec_t x;
    x.v = v; x.wr = wr; x.typ = typ; x.addr = addr; x.wdata = wdata; x.tag = tag;
    x.cv = cv; x.ctag = ctag; x.h = h; x.r = r; x.rdata = rdata;
    x.e_rdy = e_rdy; x.e_need = e_need; x.e_wr = e_wr; x.e_addr = e_addr; x.e_wdata = e_wdata;
    x.e_res = e_res; x.e_tag = e_tag; x.e_data = e_data;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    req_valid = 0; req_is_write = 0; req_type = '0; req_addr = '0; req_wdata = '0; req_tag = '0;
    commit_valid = 0; commit_tag = '0; rob_clear = 0; mem_handle = 0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic push(input logic wr, input logic [2:0] typ, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] tag);
    req_valid = 1; req_is_write = wr; req_type = typ; req_addr = addr; req_wdata = wdata; req_tag = tag;
    tick();
    req_valid = 0;
  endtask

  task automatic commit(input logic [3:0] tag);
    commit_valid = 1; commit_tag = tag;
    tick();
    commit_valid = 0;
  endtask

  task automatic wait_need(input string name);
    for (int i = 0; i < 20 && !mem_need_data; i++) tick();
    chk(name, mem_need_data, 1'b1);
  endtask

  task automatic serve_store(input string name, input logic [31:0] exp_addr);
    wait_need({name, "_need"});
    chk({name, "_addr"}, mem_addr, exp_addr);
    chk({name, "_wr"}, mem_is_write, 1'b1);
    mem_handle = 1;
    tick();
    mem_handle = 0;
  endtask

  task automatic do_load(input string name, input logic [3:0] tag, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] exp);
    push(1'b0, typ, addr, 32'h0, tag);
    wait_need({name, "_need"});
    chk({name, "_addr"}, mem_addr, addr);
    mem_handle = 1;
    tick();
    mem_handle = 0;
    mem_ready = 1; mem_rdata = rdata;
    tick();
    mem_ready = 0;
    chk({name, "_rv"}, res_valid, 1'b1);
    chk({name, "_tag"}, res_tag, tag);
    chk({name, "_data"}, res_data, exp);
    tick();
    chk({name, "_rv_off"}, res_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_need, seen_res;
    idle_in();
    rdy_in = 1; rst_in = 0;
    tick(); tick();
    chk("rst_need", mem_need_data, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    rst_in = 1;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);

    // Basic load, then a store held until commit (a non-matching commit is ignored).
    tbl.push_back(mk(1,0,3'b010,32'h100,0,3, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 1,0,32'h100,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 1,0,32'h100,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 1,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,1,32'hDEADBEEF, 1, 0,0,0,0, 1,3,32'hDEADBEEF));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,3'b010,32'h200,32'h55,5, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,6, 0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,5, 0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 1,1,32'h200,32'h55, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 1,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0));

    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_is_write = tbl[i].wr; req_type = tbl[i].typ;
      req_addr = tbl[i].addr; req_wdata = tbl[i].wdata; req_tag = tbl[i].tag;
      commit_valid = tbl[i].cv; commit_tag = tbl[i].ctag;
      mem_handle = tbl[i].h; mem_ready = tbl[i].r; mem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, tbl[i].e_rdy);
      tick();
      chk($sformatf("v%0d_need", i), mem_need_data, tbl[i].e_need);
      if (tbl[i].e_need) begin
        chk($sformatf("v%0d_wr", i), mem_is_write, tbl[i].e_wr);
        chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_addr);
        if (tbl[i].e_wr) chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      end
      chk($sformatf("v%0d_res", i), res_valid, tbl[i].e_res);
      if (tbl[i].e_res) begin
        chk($sformatf("v%0d_tag", i), res_tag, tbl[i].e_tag);
        chk($sformatf("v%0d_data", i), res_data, tbl[i].e_data);
      end
    end
    idle_in();
    tick();

    // Full queue, simultaneous pop+push, pointer wrap visible in service order.
    push(1, 3'b010, 32'h10, 32'h1, 4'd1);
    push(1, 3'b010, 32'h20, 32'h2, 4'd2);
    push(1, 3'b010, 32'h30, 32'h3, 4'd3);
    push(1, 3'b010, 32'h40, 32'h4, 4'd4);
    chk("full_ready", req_ready, 1'b0);
    commit(4'd1);
    tick();
    chk("full_issue_need", mem_need_data, 1'b1);
    chk("full_issue_addr", mem_addr, 32'h10);
    mem_handle = 1;
    req_valid = 1; req_is_write = 1; req_type = 3'b010; req_addr = 32'h60; req_wdata = 32'h6; req_tag = 4'd6;
    #1;
    chk("full_poppush_ready", req_ready, 1'b1);
    tick();
    mem_handle = 0; req_valid = 0;
    #1;
    chk("full_again_ready", req_ready, 1'b0);
    commit(4'd2); commit(4'd3); commit(4'd4); commit(4'd6);
    serve_store("wrap2", 32'h20);
    serve_store("wrap3", 32'h30);
    serve_store("wrap4", 32'h40);
    serve_store("wrap6", 32'h60);
    tick();
    chk("wrap_empty_ready", req_ready, 1'b1);

    // Flush while a committed store is in ISSUE: store survives, queued loads vanish.
    push(1, 3'b010, 32'h300, 32'h77, 4'd7);
    commit_valid = 1; commit_tag = 4'd7;
    push(0, 3'b010, 32'h80, 32'h0, 4'd8);
    commit_valid = 0;
    push(0, 3'b010, 32'h90, 32'h0, 4'd9);
    chk("clr_st_need", mem_need_data, 1'b1);
    chk("clr_st_addr", mem_addr, 32'h300);
    rob_clear = 1; req_valid = 1; req_tag = 4'd12; req_addr = 32'hC0;
    #1;
    chk("clr_push_ready", req_ready, 1'b0);
    tick();
    rob_clear = 0; req_valid = 0;
    chk("clr_st_keep", mem_need_data, 1'b1);
    chk("clr_st_wr", mem_is_write, 1'b1);
    mem_handle = 1;
    tick();
    mem_handle = 0;
    seen_need = 0; seen_res = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_need |= mem_need_data;
      seen_res  |= res_valid;
    end
    chk("clr_st_no_more_req", seen_need, 1'b0);
    chk("clr_st_no_res", seen_res, 1'b0);

    // Flush a load in WAIT: its reply is drained silently.
    push(0, 3'b010, 32'hA0, 32'h0, 4'd10);
    wait_need("drain_need");
    mem_handle = 1;
    tick();
    mem_handle = 0;
    rob_clear = 1;
    tick();
    rob_clear = 0;
    mem_ready = 1; mem_rdata = 32'h11;
    tick();
    mem_ready = 0;
    seen_res = res_valid;
    tick();
    seen_res |= res_valid;
    chk("drain_no_res", seen_res, 1'b0);
    do_load("after_drain", 4'd11, 3'b010, 32'hB0, 32'h22, 32'h22);

    // Flush a load in ISSUE before handle: request withdrawn.
    push(0, 3'b010, 32'hC0, 32'h0, 4'd12);
    wait_need("iss_clr_need");
    rob_clear = 1;
    tick();
    rob_clear = 0;
    chk("iss_clr_drop", mem_need_data, 1'b0);
    seen_need = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_need |= mem_need_data;
    end
    chk("iss_clr_stays_low", seen_need, 1'b0);

    // Load result shaping.
`ifdef MEM_REQ_EXT_EN
    do_load("sbyte", 4'd1, 3'b100, 32'h400, 32'h000000F0, 32'hFFFFFFF0);
    do_load("uhalf", 4'd2, 3'b001, 32'h404, 32'h1234ABCD, 32'h0000ABCD);
    do_load("shalf", 4'd3, 3'b101, 32'h408, 32'h00008001, 32'hFFFF8001);
`else
    do_load("sbyte", 4'd1, 3'b100, 32'h400, 32'h000000F0, 32'h000000F0);
    do_load("uhalf", 4'd2, 3'b001, 32'h404, 32'h1234ABCD, 32'h1234ABCD);
    do_load("shalf", 4'd3, 3'b101, 32'h408, 32'h00008001, 32'h00008001);
`endif

    // Freeze during ISSUE, then async reset mid-WAIT.
    push(0, 3'b001, 32'hD0, 32'h0, 4'd13);
    wait_need("frz_need");
    rdy_in = 0; mem_handle = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz%0d_need", i), mem_need_data, 1'b1);
      chk($sformatf("frz%0d_addr", i), mem_addr, 32'hD0);
    end
    rdy_in = 1;
    tick();
    mem_handle = 0;
    chk("frz_handled", mem_need_data, 1'b0);
    #2;
    rst_in = 0;
    #1;
    chk("arst_need", mem_need_data, 1'b0);
    chk("arst_wr", mem_is_write, 1'b0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_type", mem_work_type, 3'b0);
    chk("arst_res_tag", res_tag, 4'h0);
    chk("arst_res_data", res_data, 32'h0);
    chk("arst_ready", req_ready, 1'b0);
    tick();
    rst_in = 1;
    tick();
    chk("arst_release_ready", req_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
